dac_multi: RTL and testbench
============================

# dac_multi

Multi-channel, mode-selectable 1-bit DAC: the parametrised successor to the single-channel `dac`. It accepts frames of N-bit samples for CHANNELS channels through a valid/ready handshake and double-buffers them. It converts each channel to a 1-bit stream using either first-order sigma-delta or PWM. It sits between the sample source and the off-chip RC filters, one `dac_out` bit per channel.

## Interface
- `RES`, default 7: MSB index of one sample; sample width W = RES+1.
- `CHANNELS`, default 2: number of independent output channels (≥1).
- `clk`  in  1  single system clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `mode`  in  1  0 = first-order sigma-delta, 1 = PWM; sampled only at frame boundary.
- `dac_in`  in  CHANNELS*W  packed samples; channel c at bits [c*W+RES : c*W].
- `dac_in_valid`  in  1  source has a sample set on `dac_in`.
- `dac_in_ready`  out  1  shadow buffer empty; transfer when valid && ready.
- `dac_out`  out  CHANNELS  1-bit stream per channel, registered.
- `frame_start`  out  1  one-cycle pulse on the first cycle of each frame.
- `underrun`  out  1  one-cycle pulse when a frame boundary finds the shadow empty.

## Operation
- Frame counter `fcnt`, W bits, free-running 0 .. 2^W−1, wraps to 0. A frame boundary is an edge where `fcnt` == 2^W−1.
- Shadow register: loaded on valid && ready; it is then full and ready = 0.
- Active register: drives conversion.
- At a boundary with shadow full: active ← shadow, shadow emptied, and ready = 1 the next cycle.
- At a boundary with shadow empty: active holds and repeats, and `underrun` pulses for one cycle.
- Transfer with shadow empty on a boundary edge: the sample goes to the shadow, not the active register. Active repeats and `underrun` still pulses.
- Active mode register ← `mode` at each boundary. If the value changes, all sigma-delta accumulators clear on that edge.
- Sigma-delta, per channel:
  - sum = {0, acc} + {0, active_c}, (W+1) bits.
  - `dac_out[c]` ← sum[W]; acc ← sum[RES:0].
  - Constant input N gives exactly N ones in any 2^W consecutive cycles.
- PWM, per channel: `dac_out[c]` ← (fcnt < active_c). Input N gives N consecutive highs from frame start, then 2^W−N lows. N = 0 is all low; N = 2^W−1 gives one low per frame.
- Channels are fully independent; no cross-channel arithmetic.

## Timing
- Reset (rst high at an edge) gives, on the next cycle:
  - `dac_out` = 0, `frame_start` = 0, `underrun` = 0, `dac_in_ready` = 1.
  - fcnt = 0, accumulators = 0, active = 0, shadow empty, active mode = 0.
- Reset mid-frame or mid-handshake aborts everything; a sample presented during reset is not accepted.
- First cycle after reset release is fcnt = 0, but `frame_start` does not pulse until the first wrap.
- `frame_start` is high in the cycle where fcnt = 0, after a wrap.
- `dac_out` latency:
  - Output for frame position k is visible the cycle after fcnt = k.
  - A new active sample affects `dac_out` from the first cycle after `frame_start`.
- Handshake:
  - ready depends only on shadow state, never combinationally on valid.
  - valid may be held; data must be stable while valid && !ready.
- Max throughput: one sample set per frame (2^W cycles).

## Test plan
- Reset: hold rst 3 cycles mid-frame with valid = 1 → `dac_out` = 0, ready = 1, no transfer, `frame_start`/`underrun` low; fcnt restarts at 0.
- Sigma-delta (RES = 7, CHANNELS = 2), ch0 = 0x01, ch1 = 0x80, mode = 0 → every 256-cycle frame after load: ch0 exactly 1 high, ch1 exactly 128 highs in strict alternation.
- PWM:
  - mode = 1, ch0 = 0x40 → 64 consecutive highs starting in the cycle after `frame_start`, then 192 lows.
  - ch1 = 0x00 → always low.
  - ch1 = 0xFF → 255 highs, 1 low.
- Backpressure: present three sample sets back-to-back with valid held.
  - First → shadow; ready low until the boundary.
  - Second accepted the cycle after ready returns; third waits one further frame.
  - No sample lost or duplicated.
- Underrun: load 0x10, then stop → `underrun` pulses at each subsequent boundary and the output keeps 16 highs per frame.
- Mode switch: toggle `mode` mid-frame → output behaviour changes only from the next `frame_start`, and the sigma-delta accumulator starts from 0.

Source files
------------

// File: rtl/dac_multi.sv
// Multi-channel 1-bit DAC: double-buffered sample frames converted per channel
// by first-order sigma-delta or PWM, selected per frame.
module dac_multi #(
    parameter int RES      = 7,
    parameter int CHANNELS = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          mode,
    input  logic [CHANNELS*(RES+1)-1:0]   dac_in,
    input  logic                          dac_in_valid,
    output logic                          dac_in_ready,
    output logic [CHANNELS-1:0]           dac_out,
    output logic                          frame_start,
    output logic                          underrun
);

    localparam int W = RES + 1;

    typedef enum logic {
        SH_EMPTY = 1'b0,
        SH_FULL  = 1'b1
    } shadow_state_t;

    shadow_state_t             sh_state, sh_next;
    logic [RES:0]              fcnt;
    logic [CHANNELS*W-1:0]     shadow;
    logic [CHANNELS*W-1:0]     active;
    logic                      mode_act;
    logic [RES:0]              acc      [CHANNELS];
    logic [RES:0]              nxt_acc  [CHANNELS];
    logic [W:0]                sum      [CHANNELS];
    logic [RES:0]              sample   [CHANNELS];
    logic [CHANNELS-1:0]       nxt_out;
    logic                      boundary;
    logic                      xfer;
    logic                      mode_change;

    assign boundary     = (fcnt == '1);
    assign dac_in_ready = (sh_state == SH_EMPTY);
    assign xfer         = dac_in_valid && dac_in_ready;
    assign mode_change  = boundary && (mode != mode_act);

    // A full shadow cannot accept, so the boundary drain and a new load never collide.
    always_comb begin
        sh_next = sh_state;
        case (sh_state)
            SH_EMPTY: if (xfer)     sh_next = SH_FULL;
            SH_FULL:  if (boundary) sh_next = SH_EMPTY;
            default:                sh_next = SH_EMPTY;
        endcase
    end

    always_comb begin
        nxt_out = '0;
        for (int unsigned c = 0; c < CHANNELS; c++) begin
            sample[c]  = active[c*W +: W];
            sum[c]     = {1'b0, acc[c]} + {1'b0, sample[c]};
            nxt_acc[c] = acc[c];
            if (mode_act) begin
                nxt_out[c] = (fcnt < sample[c]);
            end else begin
                nxt_out[c] = sum[c][W];
                nxt_acc[c] = sum[c][RES:0];
            end
            // A new mode takes effect next frame; sigma-delta restarts from a clean accumulator.
            if (mode_change)
                nxt_acc[c] = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh_state    <= SH_EMPTY;
            fcnt        <= '0;
            shadow      <= '0;
            active      <= '0;
            mode_act    <= 1'b0;
            dac_out     <= '0;
            frame_start <= 1'b0;
            underrun    <= 1'b0;
            for (int unsigned c = 0; c < CHANNELS; c++)
                acc[c] <= '0;
        end else begin
            sh_state    <= sh_next;
            fcnt        <= fcnt + 1'b1;
            frame_start <= boundary;
            underrun    <= boundary && (sh_state == SH_EMPTY);
            dac_out     <= nxt_out;
            if (xfer)
                shadow <= dac_in;
            if (boundary && (sh_state == SH_FULL))
                active <= shadow;
            if (boundary)
                mode_act <= mode;
            for (int unsigned c = 0; c < CHANNELS; c++)
                acc[c] <= nxt_acc[c];
        end
    end

endmodule

// File: tb/tb_dac_multi.sv
// Directed plus randomized bench for dac_multi, checked cycle by cycle against
// an arithmetic frame-level model and per-frame high counts.
module tb_dac_multi;

    localparam int RES  = 7;
    localparam int CH   = 2;
    localparam int W    = RES + 1;
    localparam int FLEN = 1 << W;

    logic              clk = 1'b0;
    logic              rst;
    logic              mode;
    logic [CH*W-1:0]   dac_in;
    logic              dac_in_valid;
    logic              dac_in_ready;
    logic [CH-1:0]     dac_out;
    logic              frame_start;
    logic              underrun;

    dac_multi #(.RES(RES), .CHANNELS(CH)) dut (
        .clk          (clk),
        .rst          (rst),
        .mode         (mode),
        .dac_in       (dac_in),
        .dac_in_valid (dac_in_valid),
        .dac_in_ready (dac_in_ready),
        .dac_out      (dac_out),
        .frame_start  (frame_start),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Source of sample sets; the front is held on dac_in until accepted.
    logic [CH*W-1:0] src_q[$];
    logic rst_v;
    logic mode_v;

    // Behavioural model state
    int m_fcnt, m_full, m_mode;
    int m_sh[CH], m_act[CH], m_acc[CH];
    logic [CH-1:0] m_out;
    logic m_fs, m_ur, m_ready;

    // Per-frame high counting
    int hi_cnt[CH];
    int rec_act[CH];
    bit rec_valid;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [CH*W-1:0] pack(input int ch0, input int ch1);
        logic [CH*W-1:0] v;
        v = '0;
        v[0 +: W] = ch0[W-1:0];
        v[W +: W] = ch1[W-1:0];
        return v;
    endfunction

    task automatic model_step(input logic r, input logic accept, input logic [CH*W-1:0] d, input logic md);
        bit bnd, pre_full;
        int s;
        if (r) begin
            m_fcnt = 0; m_full = 0; m_mode = 0;
            for (int c = 0; c < CH; c++) begin
                m_sh[c] = 0; m_act[c] = 0; m_acc[c] = 0;
            end
            m_out = '0; m_fs = 0; m_ur = 0; m_ready = 1;
            return;
        end
        bnd = (m_fcnt == FLEN - 1);
        pre_full = (m_full != 0);
        for (int c = 0; c < CH; c++) begin
            if (m_mode != 0) begin
                m_out[c] = (m_fcnt < m_act[c]);
            end else begin
                s = m_acc[c] + m_act[c];
                m_out[c] = (s >= FLEN);
                m_acc[c] = s % FLEN;
            end
        end
        if (bnd && (int'(md) != m_mode))
            for (int c = 0; c < CH; c++) m_acc[c] = 0;
        m_fs = bnd;
        m_ur = bnd && !pre_full;
        if (bnd && pre_full) begin
            for (int c = 0; c < CH; c++) m_act[c] = m_sh[c];
            m_full = 0;
        end
        if (accept) begin
            for (int c = 0; c < CH; c++) m_sh[c] = int'(d[c*W +: W]);
            m_full = 1;
        end
        if (bnd) m_mode = int'(md);
        m_fcnt = (m_fcnt + 1) % FLEN;
        m_ready = (m_full == 0);
    endtask

    task automatic cyc();
        logic v, acc_x;
        logic [CH*W-1:0] d;
        @(negedge clk);
        v = (src_q.size() > 0);
        d = v ? src_q[0] : CH*W'($urandom);
        rst = rst_v;
        mode = mode_v;
        dac_in_valid = v;
        dac_in = d;
        acc_x = v && m_ready && !rst_v;
        model_step(rst_v, acc_x, d, mode_v);
        if (acc_x) void'(src_q.pop_front());
        @(posedge clk);
        #1;
        chk("dac_out", 32'(dac_out), 32'(m_out));
        chk("ready", 32'(dac_in_ready), 32'(m_ready));
        chk("frame_start", 32'(frame_start), 32'(m_fs));
        chk("underrun", 32'(underrun), 32'(m_ur));
        if (rst_v) begin
            rec_valid = 0;
            for (int c = 0; c < CH; c++) hi_cnt[c] = 0;
        end else begin
            for (int c = 0; c < CH; c++) hi_cnt[c] += int'(dac_out[c]);
            if (m_fs) begin
                if (rec_valid)
                    for (int c = 0; c < CH; c++)
                        chk($sformatf("frame_highs_ch%0d", c), 32'(hi_cnt[c]), 32'(rec_act[c]));
                for (int c = 0; c < CH; c++) begin
                    rec_act[c] = m_act[c];
                    hi_cnt[c] = 0;
                end
                rec_valid = 1;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    initial begin
        rst = 1'b1; mode = 1'b0; dac_in = '0; dac_in_valid = 1'b0;
        rst_v = 1'b1; mode_v = 1'b0; rec_valid = 0;
        m_ready = 1;
        for (int c = 0; c < CH; c++) hi_cnt[c] = 0;

        // Reset
        run(2);
        rst_v = 1'b0;

        // Sigma-delta: ch0 = 0x01, ch1 = 0x80
        src_q.push_back(pack(8'h01, 8'h80));
        run(4 * FLEN);

        // Backpressure: three sets back to back, valid held
        for (int i = 0; i < 3; i++)
            src_q.push_back(pack($urandom_range(0, FLEN - 1), $urandom_range(0, FLEN - 1)));
        run(5 * FLEN);
        chk("backpressure_drained", 32'(src_q.size()), 32'd0);

        // Underrun: load 0x10 then stop
        src_q.push_back(pack(8'h10, 8'h10));
        run(4 * FLEN);

        // PWM switched in mid-frame
        run(100);
        mode_v = 1'b1;
        src_q.push_back(pack(8'h40, 8'h00));
        run(3 * FLEN);
        src_q.push_back(pack(8'h40, 8'hFF));
        run(3 * FLEN);

        // Back to sigma-delta mid-frame
        run(77);
        mode_v = 1'b0;
        run(3 * FLEN);

        // Randomized traffic and mode toggles
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 1)
                src_q.push_back(pack($urandom_range(0, FLEN - 1), $urandom_range(0, FLEN - 1)));
            if ($urandom_range(0, 3) == 0)
                mode_v = ~mode_v;
            run($urandom_range(100, 400));
        end

        // Reset mid-frame with valid asserted
        src_q.push_back(pack($urandom_range(0, FLEN - 1), $urandom_range(0, FLEN - 1)));
        rst_v = 1'b1;
        run(3);
        rst_v = 1'b0;
        run(2 * FLEN + 10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
